pipeline_hazard_ctrl: RTL and testbench

Central hazard and sequencing controller for the 5-stage RV32I pipeline. It watches the IF/ID, ID/EX, EX/MEM and MEM/WB instruction registers, the raw branch decision from the execute stage, and the data-bus ready signal. It produces the stall, bubble, flush and forwarding-select controls that sequence the execute datapath. It replaces ad-hoc branch-shadow buffers and per-stage forwarding decodes with one state machine.

---
 rtl/rv_pipe_pkg.sv | 60 ++++++
 rtl/fwd_select.sv | 36 +++
 rtl/pipeline_hazard_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pipe_pkg.sv
// Shared RV32I pipeline definitions: opcodes, forwarding selects, hazard FSM states
// and the register-usage decode helpers used by the hazard controller.
package rv_pipe_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYS    = 7'b1110011;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EXM = 2'b01;
    localparam logic [1:0] FWD_MWB = 2'b10;
    localparam logic [1:0] FWD_LD  = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDSTALL = 2'd1,
        ST_SHADOW  = 2'd2,
        ST_MEMWAIT = 2'd3
    } ctrl_state_e;

    function automatic logic writes_rd(input logic [6:0] opc);
        logic w;
        w = 1'b0;
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
            OPC_LOAD, OPC_OP_IMM, OPC_OP, OPC_SYS: w = 1'b1;
            default:                               w = 1'b0;
        endcase
        return w;
    endfunction

    function automatic logic reads_rs1(input logic [6:0] opc);
        logic w;
        w = 1'b0;
        case (opc)
            OPC_JALR, OPC_BRANCH, OPC_LOAD,
            OPC_STORE, OPC_OP_IMM, OPC_OP: w = 1'b1;
            default:                       w = 1'b0;
        endcase
        return w;
    endfunction

    function automatic logic reads_rs2(input logic [6:0] opc);
        logic w;
        w = 1'b0;
        case (opc)
            OPC_BRANCH, OPC_STORE, OPC_OP: w = 1'b1;
            default:                       w = 1'b0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Operand forwarding select for one source register of the instruction in ID/EX.
// The younger EX/MEM producer wins over MEM/WB; a load in EX/MEM uses the bus data path.
module fwd_select
    import rv_pipe_pkg::*;
(
    input  logic [4:0]  i_rs,
    input  logic        i_rs_en,
    input  logic [31:0] i_exm_inst,
    input  logic [31:0] i_mwb_inst,
    output logic [1:0]  o_sel
);

    logic w_exm_hit;
    logic w_mwb_hit;
    logic w_exm_load;
    logic w_unused_bits;

    // x0 is never a real producer, so a zero source register never forwards
    assign w_exm_hit  = i_rs_en && (i_rs != 5'd0) && writes_rd(i_exm_inst[6:0])
                        && (i_exm_inst[11:7] == i_rs);
    assign w_mwb_hit  = i_rs_en && (i_rs != 5'd0) && writes_rd(i_mwb_inst[6:0])
                        && (i_mwb_inst[11:7] == i_rs);
    assign w_exm_load = (i_exm_inst[6:0] == OPC_LOAD);

    always_comb begin
        o_sel = FWD_RF;
        if (w_exm_hit) begin
            o_sel = w_exm_load ? FWD_LD : FWD_EXM;
        end else if (w_mwb_hit) begin
            o_sel = FWD_MWB;
        end
    end

    assign w_unused_bits = &{1'b0, i_exm_inst[31:12], i_mwb_inst[31:12]};

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32I pipeline: memory wait, branch
// shadow, load-use stall and forwarding selects. Optional counters: HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl
    import rv_pipe_pkg::*;
#(
    parameter int BR_SHADOW = 2,
    parameter int CNT_W     = 32
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic [31:0] ID_inst,
    input  logic [31:0] ID_EX_inst,
    input  logic [31:0] EX_MEM_inst,
    input  logic [31:0] MEM_WB_inst,
    input  logic        br_raw,
    input  logic        HREADY_D,
    output logic        stall_if,
    output logic        stall_id,
    output logic        stall_ex,
    output logic        bubble_ex,
    output logic        flush_if_id,
    output logic        branch_taken,
    output logic [1:0]  fwd_rs1_sel,
    output logic [1:0]  fwd_rs2_sel,
    output logic [1:0]  ctrl_state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] memwait_cycles
`endif
);

    ctrl_state_e r_state;
    ctrl_state_e r_saved_state;
    ctrl_state_e w_state_next;
    ctrl_state_e w_saved_next;
    ctrl_state_e w_eff_state;
    logic [1:0]  r_shadow_cnt;
    logic [1:0]  w_shadow_cnt_next;

    logic        w_memwait;
    logic        w_load_use;
    logic        w_stall_if;
    logic        w_stall_id;
    logic        w_stall_ex;
    logic        w_bubble_ex;
    logic        w_flush_if_id;
    logic        w_branch_taken;
    logic [1:0]  w_fwd_rs1;
    logic [1:0]  w_fwd_rs2;
    logic        w_unused_bits;

    assign w_memwait = ((EX_MEM_inst[6:0] == OPC_LOAD) || (EX_MEM_inst[6:0] == OPC_STORE))
                       && !HREADY_D;

    assign w_load_use = (ID_EX_inst[6:0] == OPC_LOAD) && (ID_EX_inst[11:7] != 5'd0)
                        && ((reads_rs1(ID_inst[6:0]) && (ID_inst[19:15] == ID_EX_inst[11:7]))
                         || (reads_rs2(ID_inst[6:0]) && (ID_inst[24:20] == ID_EX_inst[11:7])));

    // Once the bus completes, MEMWAIT behaves as the state it interrupted for that cycle
    assign w_eff_state = (r_state == ST_MEMWAIT) ? r_saved_state : r_state;

    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            r_state       <= ST_RUN;
            r_saved_state <= ST_RUN;
            r_shadow_cnt  <= 2'd0;
        end else begin
            r_state       <= w_state_next;
            r_saved_state <= w_saved_next;
            r_shadow_cnt  <= w_shadow_cnt_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_saved_next      = r_saved_state;
        w_shadow_cnt_next = r_shadow_cnt;
        w_stall_if        = 1'b0;
        w_stall_id        = 1'b0;
        w_stall_ex        = 1'b0;
        w_bubble_ex       = 1'b0;
        w_flush_if_id     = 1'b0;
        w_branch_taken    = 1'b0;

        if (w_memwait) begin
            w_stall_if   = 1'b1;
            w_stall_id   = 1'b1;
            w_stall_ex   = 1'b1;
            w_state_next = ST_MEMWAIT;
            if (r_state != ST_MEMWAIT) begin
                w_saved_next = r_state;
            end
        end else begin
            w_state_next = w_eff_state;
            case (w_eff_state)
                ST_RUN, ST_LDSTALL: begin
                    if (br_raw) begin
                        w_branch_taken    = 1'b1;
                        w_flush_if_id     = 1'b1;
                        w_bubble_ex       = 1'b1;
                        w_shadow_cnt_next = 2'(BR_SHADOW);
                        w_state_next      = ST_SHADOW;
                    end else if ((w_eff_state == ST_RUN) && w_load_use) begin
                        w_stall_if   = 1'b1;
                        w_stall_id   = 1'b1;
                        w_bubble_ex  = 1'b1;
                        w_state_next = ST_LDSTALL;
                    end else begin
                        w_state_next = ST_RUN;
                    end
                end
                ST_SHADOW: begin
                    if (w_load_use) begin
                        w_stall_if  = 1'b1;
                        w_stall_id  = 1'b1;
                        w_bubble_ex = 1'b1;
                    end
                    if (r_shadow_cnt <= 2'd1) begin
                        w_shadow_cnt_next = 2'd0;
                        w_state_next      = ST_RUN;
                    end else begin
                        w_shadow_cnt_next = r_shadow_cnt - 2'd1;
                    end
                end
                default: begin
                    w_state_next = ST_RUN;
                end
            endcase
        end
    end

    fwd_select u_fwd_rs1 (
        .i_rs       (ID_EX_inst[19:15]),
        .i_rs_en    (reads_rs1(ID_EX_inst[6:0])),
        .i_exm_inst (EX_MEM_inst),
        .i_mwb_inst (MEM_WB_inst),
        .o_sel      (w_fwd_rs1)
    );

    fwd_select u_fwd_rs2 (
        .i_rs       (ID_EX_inst[24:20]),
        .i_rs_en    (reads_rs2(ID_EX_inst[6:0])),
        .i_exm_inst (EX_MEM_inst),
        .i_mwb_inst (MEM_WB_inst),
        .o_sel      (w_fwd_rs2)
    );

    // Outputs are forced quiet while reset is asserted, independent of the inputs
    assign stall_if     = RES & w_stall_if;
    assign stall_id     = RES & w_stall_id;
    assign stall_ex     = RES & w_stall_ex;
    assign bubble_ex    = RES & w_bubble_ex;
    assign flush_if_id  = RES & w_flush_if_id;
    assign branch_taken = RES & w_branch_taken;
    assign fwd_rs1_sel  = RES ? w_fwd_rs1 : FWD_RF;
    assign fwd_rs2_sel  = RES ? w_fwd_rs2 : FWD_RF;
    assign ctrl_state   = r_state;

    assign w_unused_bits = &{1'b0, ID_inst[31:25], ID_inst[14:7],
                             ID_EX_inst[31:25], ID_EX_inst[14:12]};

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_count;
    logic [CNT_W-1:0] r_memwait_cycles;

    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            r_stall_cycles   <= '0;
            r_flush_count    <= '0;
            r_memwait_cycles <= '0;
        end else begin
            if (w_stall_if && !(&r_stall_cycles)) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
            if (w_branch_taken && !(&r_flush_count)) begin
                r_flush_count <= r_flush_count + CNT_W'(1);
            end
            if (w_memwait && !(&r_memwait_cycles)) begin
                r_memwait_cycles <= r_memwait_cycles + CNT_W'(1);
            end
        end
    end

    assign stall_cycles   = r_stall_cycles;
    assign flush_count    = r_flush_count;
    assign memwait_cycles = r_memwait_cycles;
`else
    logic [CNT_W-1:0] w_unused_cnt;
    assign w_unused_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl; counter checks are compiled in
// when HAZARD_PERF_CNT_EN is defined.
module tb_pipeline_hazard_ctrl;
    import rv_pipe_pkg::*;

    logic        CLK = 1'b0;
    logic        RES = 1'b0;
    logic [31:0] ID_inst = '0;
    logic [31:0] ID_EX_inst = '0;
    logic [31:0] EX_MEM_inst = '0;
    logic [31:0] MEM_WB_inst = '0;
    logic        br_raw = 1'b0;
    logic        HREADY_D = 1'b1;
    logic        stall_if, stall_id, stall_ex, bubble_ex, flush_if_id, branch_taken;
    logic [1:0]  fwd_rs1_sel, fwd_rs2_sel, ctrl_state;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_count, memwait_cycles;
`endif

    pipeline_hazard_ctrl #(.BR_SHADOW(2), .CNT_W(32)) dut (
        .CLK          (CLK),
        .RES          (RES),
        .ID_inst      (ID_inst),
        .ID_EX_inst   (ID_EX_inst),
        .EX_MEM_inst  (EX_MEM_inst),
        .MEM_WB_inst  (MEM_WB_inst),
        .br_raw       (br_raw),
        .HREADY_D     (HREADY_D),
        .stall_if     (stall_if),
        .stall_id     (stall_id),
        .stall_ex     (stall_ex),
        .bubble_ex    (bubble_ex),
        .flush_if_id  (flush_if_id),
        .branch_taken (branch_taken),
        .fwd_rs1_sel  (fwd_rs1_sel),
        .fwd_rs2_sel  (fwd_rs2_sel),
        .ctrl_state   (ctrl_state)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles   (stall_cycles),
        .flush_count    (flush_count),
        .memwait_cycles (memwait_cycles)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       tag;
        logic [11:0] exp;
    } exp_t;

    exp_t        expQ[$];
    int          totalChecks = 0;
    int          badChecks   = 0;
    logic [11:0] obsVec;

    // {stall_if, stall_id, stall_ex, bubble_ex, flush_if_id, branch_taken, rs1, rs2, state}
    assign obsVec = {stall_if, stall_id, stall_ex, bubble_ex, flush_if_id, branch_taken,
                     fwd_rs1_sel, fwd_rs2_sel, ctrl_state};

    function automatic logic [11:0] mkExp(input logic si, input logic sd, input logic se,
                                          input logic bub, input logic fl, input logic bt,
                                          input logic [1:0] f1, input logic [1:0] f2,
                                          input logic [1:0] st);
        return {si, sd, se, bub, fl, bt, f1, f2, st};
    endfunction

    function automatic logic [31:0] encR(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [6:0] opc);
        return {f7, rs2, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] encI(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] encS(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [6:0] opc);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %h, want %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input string tag, input logic [31:0] id,
                                 input logic [31:0] idex, input logic [31:0] exm,
                                 input logic [31:0] mwb, input logic br, input logic hr,
                                 input logic [11:0] exp);
        exp_t e;
        ID_inst     = id;
        ID_EX_inst  = idex;
        EX_MEM_inst = exm;
        MEM_WB_inst = mwb;
        br_raw      = br;
        HREADY_D    = hr;
        e.tag = tag;
        e.exp = exp;
        expQ.push_back(e);
    endtask

    task automatic sampleOutputs();
        exp_t e;
        if (expQ.size() == 0) begin
            badChecks++;
            $display("[TB] FAIL scoreboard: got 0 pending entries, want at least 1");
            return;
        end
        e = expQ.pop_front();
        checkOutput(e.tag, {20'd0, obsVec}, {20'd0, e.exp});
    endtask

    task automatic step(input string tag, input logic [31:0] id, input logic [31:0] idex,
                        input logic [31:0] exm, input logic [31:0] mwb, input logic br,
                        input logic hr, input logic [11:0] exp);
        @(posedge CLK);
        #1;
        applyStimulus(tag, id, idex, exm, mwb, br, hr, exp);
        @(negedge CLK);
        sampleOutputs();
    endtask

    task automatic clearInputs();
        ID_inst     = '0;
        ID_EX_inst  = '0;
        EX_MEM_inst = '0;
        MEM_WB_inst = '0;
        br_raw      = 1'b0;
        HREADY_D    = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] LW_X5, ADD_X6_X5_X2, LW_X0, ADD_X6_X0_X0, SW_X2, SW_IMM3;
        logic [31:0] ADDI_X3, SUB_X4, LW_X3, ADDI_X4_X3_3;
        logic [11:0] IDLE_RUN, IDLE_SHD, BR_RUN;

        LW_X5        = encI(12'd0, 5'd1, 3'b010, 5'd5, OPC_LOAD);
        ADD_X6_X5_X2 = encR(7'd0, 5'd2, 5'd5, 3'b000, 5'd6, OPC_OP);
        LW_X0        = encI(12'd0, 5'd1, 3'b010, 5'd0, OPC_LOAD);
        ADD_X6_X0_X0 = encR(7'd0, 5'd0, 5'd0, 3'b000, 5'd6, OPC_OP);
        SW_X2        = encS(12'd0, 5'd2, 5'd1, 3'b010, OPC_STORE);
        SW_IMM3      = encS(12'd3, 5'd2, 5'd1, 3'b010, OPC_STORE);
        ADDI_X3      = encI(12'd1, 5'd0, 3'b000, 5'd3, OPC_OP_IMM);
        SUB_X4       = encR(7'h20, 5'd3, 5'd3, 3'b000, 5'd4, OPC_OP);
        LW_X3        = encI(12'd0, 5'd1, 3'b010, 5'd3, OPC_LOAD);
        ADDI_X4_X3_3 = encI(12'd3, 5'd3, 3'b000, 5'd4, OPC_OP_IMM);
        IDLE_RUN     = mkExp(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'd0);
        IDLE_SHD     = mkExp(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'd2);
        BR_RUN       = mkExp(0, 0, 0, 1, 1, 1, 2'b00, 2'b00, 2'd0);

        // Outputs must stay quiet under reset even with a branch and load-use presented
        #3;
        applyStimulus("reset_outputs", ADD_X6_X5_X2, LW_X5, 32'd0, 32'd0, 1'b1, 1'b1, IDLE_RUN);
        #1;
        sampleOutputs();
        clearInputs();
        @(negedge CLK);
        RES = 1'b1;

        // Branch shadow: two masked cycles, then the next branch is accepted
        step("br_first",   0, 0, 0, 0, 1'b1, 1'b1, BR_RUN);
        step("br_mask1",   0, 0, 0, 0, 1'b1, 1'b1, IDLE_SHD);
        step("br_mask2",   0, 0, 0, 0, 1'b1, 1'b1, IDLE_SHD);
        step("br_again",   0, 0, 0, 0, 1'b1, 1'b1, BR_RUN);
        step("shd_cnt2",   0, 0, 0, 0, 1'b0, 1'b1, IDLE_SHD);

        // Mid-shadow with counter at 1: load-use stalls in place, then async reset
        @(posedge CLK);
        #1;
        applyStimulus("shadow_ldu", ADD_X6_X5_X2, LW_X5, 0, 0, 1'b1, 1'b1,
                      mkExp(1, 1, 0, 1, 0, 0, 2'b00, 2'b00, 2'd2));
        #1;
        sampleOutputs();
        #1;
        RES = 1'b0;
        applyStimulus("async_reset", ADD_X6_X5_X2, LW_X5, 0, 0, 1'b1, 1'b1, IDLE_RUN);
        #1;
        sampleOutputs();
        @(posedge CLK);
        #1;
        RES = 1'b1;
        applyStimulus("post_reset_br", 0, 0, 0, 0, 1'b1, 1'b1, BR_RUN);
        @(negedge CLK);
        sampleOutputs();
        step("prb_shd1",   0, 0, 0, 0, 1'b0, 1'b1, IDLE_SHD);
        step("prb_shd2",   0, 0, 0, 0, 1'b0, 1'b1, IDLE_SHD);

        // Fresh reset so the counters cover only the load-use and memwait scenarios
        @(posedge CLK);
        #1;
        RES = 1'b0;
        clearInputs();
`ifdef HAZARD_PERF_CNT_EN
        #1;
        checkOutput("perf_clr_stall", stall_cycles, 32'd0);
        checkOutput("perf_clr_flush", flush_count, 32'd0);
        checkOutput("perf_clr_mwait", memwait_cycles, 32'd0);
`endif
        @(posedge CLK);
        #1;
        RES = 1'b1;

        // Load-use then load forwarding from EX/MEM
        step("ldu_stall",  ADD_X6_X5_X2, LW_X5, 0, 0, 1'b0, 1'b1,
             mkExp(1, 1, 0, 1, 0, 0, 2'b00, 2'b00, 2'd0));
        step("ldu_fwd",    0, ADD_X6_X5_X2, LW_X5, 0, 1'b0, 1'b1,
             mkExp(0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'd1));

        // x0 never hazards or forwards
        step("x0_nostall", ADD_X6_X0_X0, LW_X0, 0, 0, 1'b0, 1'b1, IDLE_RUN);
        step("x0_nofwd",   0, ADD_X6_X0_X0, LW_X0, 0, 1'b0, 1'b1, IDLE_RUN);

        // Memwait beats a branch for three cycles, branch taken on completion
        for (int i = 0; i < 3; i++) begin
            step($sformatf("mw_stall%0d", i), 0, 0, SW_X2, 0, 1'b1, 1'b0,
                 mkExp(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, (i == 0) ? 2'd0 : 2'd3));
        end
        step("mw_release", 0, 0, SW_X2, 0, 1'b1, 1'b1,
             mkExp(0, 0, 0, 1, 1, 1, 2'b00, 2'b00, 2'd3));
        step("mw_shd1",    0, 0, 0, 0, 1'b0, 1'b1, IDLE_SHD);
        step("mw_shd2",    0, 0, 0, 0, 1'b0, 1'b1, IDLE_SHD);
`ifdef HAZARD_PERF_CNT_EN
        checkOutput("perf_stall", stall_cycles, 32'd4);
        checkOutput("perf_flush", flush_count, 32'd1);
        checkOutput("perf_mwait", memwait_cycles, 32'd3);
`endif

        // Memwait inside the shadow freezes the shadow counter
        step("fz_br",      0, 0, 0, 0, 1'b1, 1'b1, BR_RUN);
        step("fz_wait1",   0, 0, SW_X2, 0, 1'b1, 1'b0,
             mkExp(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'd2));
        step("fz_wait2",   0, 0, SW_X2, 0, 1'b1, 1'b0,
             mkExp(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'd3));
        step("fz_resume",  0, 0, 0, 0, 1'b1, 1'b1,
             mkExp(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'd3));
        step("fz_last",    0, 0, 0, 0, 1'b1, 1'b1, IDLE_SHD);
        step("fz_br2",     0, 0, 0, 0, 1'b1, 1'b1, BR_RUN);
        step("fz_shd1",    0, 0, 0, 0, 1'b0, 1'b1, IDLE_SHD);
        step("fz_shd2",    0, 0, 0, 0, 1'b0, 1'b1, IDLE_SHD);

        // Forwarding priority and operand-use qualification
        step("fwd_exm",    0, SUB_X4, ADDI_X3, ADDI_X3, 1'b0, 1'b1,
             mkExp(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'd0));
        step("fwd_mwb",    0, SUB_X4, 0, ADDI_X3, 1'b0, 1'b1,
             mkExp(0, 0, 0, 0, 0, 0, 2'b10, 2'b10, 2'd0));
        step("fwd_ld",     0, SUB_X4, LW_X3, ADDI_X3, 1'b0, 1'b1,
             mkExp(0, 0, 0, 0, 0, 0, 2'b11, 2'b11, 2'd0));
        step("fwd_store",  0, SUB_X4, SW_IMM3, ADDI_X3, 1'b0, 1'b1,
             mkExp(0, 0, 0, 0, 0, 0, 2'b10, 2'b10, 2'd0));
        step("fwd_imm",    0, ADDI_X4_X3_3, 0, ADDI_X3, 1'b0, 1'b1,
             mkExp(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'd0));

        if (expQ.size() != 0) begin
            badChecks++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending entries, want 0", expQ.size());
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
